// File: rtl/opcode_stream_decoder.sv
// Bytecode fetch-stream decoder: splits single-byte opcodes from 0xff-prefixed
// extended opcodes, emits one strobe per instruction and keeps saturating counts.
module opcode_stream_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        hold,
  output logic [7:0]  opcode_1,
  output logic [7:0]  opcode_2,
  output logic        valid_op,
  output logic [31:0] instr_count,
  output logic [15:0] ext_count,
  output logic        prefix_err
);

  typedef enum logic {
    IDLE,
    PREFIX
  } state_t;

  localparam logic [7:0] EXT_PREFIX = 8'hff;
  // The counter compare is done on the pre-increment value so the abort lands
  // in the same cycle the count reaches PREFIX_TIMEOUT-1.
  localparam logic [7:0] TMO_LAST   = 8'(PREFIX_TIMEOUT - 2);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_cnt_nxt;
  logic       accept;
  logic       load_plain;
  logic       load_ext;
  logic       timeout;

  assign byte_ready = !hold && !reset;
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    load_plain  = 1'b0;
    load_ext    = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (byte_in == EXT_PREFIX) begin
            state_nxt   = PREFIX;
            tmo_cnt_nxt = '0;
          end else begin
            load_plain = 1'b1;
          end
        end
      end
      PREFIX: begin
        if (accept) begin
          load_ext    = 1'b1;
          state_nxt   = IDLE;
          tmo_cnt_nxt = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout     = 1'b1;
          state_nxt   = IDLE;
          tmo_cnt_nxt = '0;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        tmo_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      opcode_1    <= '0;
      opcode_2    <= '0;
      valid_op    <= 1'b0;
      instr_count <= '0;
      ext_count   <= '0;
      prefix_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      valid_op <= load_plain || load_ext;
      if (load_plain) begin
        opcode_1 <= byte_in;
        opcode_2 <= '0;
      end else if (load_ext) begin
        opcode_1 <= EXT_PREFIX;
        opcode_2 <= byte_in;
      end
      if (timeout) begin
        prefix_err <= 1'b1;
      end
      if (valid_op && (instr_count != '1)) begin
        instr_count <= instr_count + 32'd1;
      end
      if (valid_op && (opcode_1 == EXT_PREFIX) && (ext_count != '1)) begin
        ext_count <= ext_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_opcode_stream_decoder.sv
// Directed bench for opcode_stream_decoder with a scoreboard of expected
// instructions tagged by the cycle their byte was presented.
module tb_opcode_stream_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        hold;
  logic [7:0]  opcode_1;
  logic [7:0]  opcode_2;
  logic        valid_op;
  logic [31:0] instr_count;
  logic [15:0] ext_count;
  logic        prefix_err;

  opcode_stream_decoder #(.PREFIX_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .hold       (hold),
    .opcode_1   (opcode_1),
    .opcode_2   (opcode_2),
    .valid_op   (valid_op),
    .instr_count(instr_count),
    .ext_count  (ext_count),
    .prefix_err (prefix_err)
  );

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned exp_instr = 0;
  int unsigned exp_ext = 0;
  logic        in_prefix = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expectation, one cycle after its byte.
  always @(negedge clk) begin
    if (valid_op === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("opcode_pair", {16'h0, opcode_1, opcode_2}, {16'h0, e.op1, e.op2});
        chk("strobe_latency_cycle", cyc, e.cyc + 1);
        exp_instr++;
        if (e.op1 == 8'hff) exp_ext++;
      end
    end
  end

  task automatic push_exp(input logic [7:0] o1, input logic [7:0] o2);
    exp_t e;
    e.op1 = o1;
    e.op2 = o2;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic h);
    byte_valid = v;
    byte_in    = b;
    hold       = h;
    if (v && !h && !reset) begin
      if (in_prefix) begin
        push_exp(8'hff, b);
        in_prefix = 1'b0;
      end else if (b == 8'hff) begin
        in_prefix = 1'b1;
      end else begin
        push_exp(b, 8'h00);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    reset      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h77;
    hold       = 1'b0;
    #1;
    chk({tag, "_byte_ready_in_reset"}, {31'h0, byte_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_opcode_1"}, {24'h0, opcode_1}, 32'h0);
    chk({tag, "_opcode_2"}, {24'h0, opcode_2}, 32'h0);
    chk({tag, "_valid_op"}, {31'h0, valid_op}, 32'd0);
    chk({tag, "_instr_count"}, instr_count, 32'd0);
    chk({tag, "_ext_count"}, {16'h0, ext_count}, 32'd0);
    chk({tag, "_prefix_err"}, {31'h0, prefix_err}, 32'd0);
    reset      = 1'b0;
    byte_valid = 1'b0;
    exp_q.delete();
    in_prefix  = 1'b0;
    exp_instr  = 0;
    exp_ext    = 0;
  endtask

  initial begin
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    hold       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset("init");

    // Three plain opcodes back to back
    drive(1'b1, 8'h10, 1'b0);
    drive(1'b1, 8'h60, 1'b0);
    drive(1'b1, 8'hb1, 1'b0);
    idle(2);
    chk("plain_instr_count", instr_count, 32'd3);
    chk("plain_ext_count", {16'h0, ext_count}, 32'd0);
    chk("plain_instr_count_model", instr_count, 32'(exp_instr));

    // Extended opcodes, including 0xff as the second byte
    drive(1'b1, 8'hff, 1'b0);
    drive(1'b1, 8'h2a, 1'b0);
    drive(1'b1, 8'hff, 1'b0);
    drive(1'b1, 8'hff, 1'b0);
    idle(2);
    chk("ext_ext_count", {16'h0, ext_count}, 32'd2);
    chk("ext_instr_count", instr_count, 32'(exp_instr));
    chk("ext_prefix_err", {31'h0, prefix_err}, 32'd0);

    // Prefix timeout: abort lands on the 15th idle cycle
    drive(1'b1, 8'hff, 1'b0);
    idle(14);
    chk("tmo_err_before_limit", {31'h0, prefix_err}, 32'd0);
    idle(1);
    chk("tmo_err_set", {31'h0, prefix_err}, 32'd1);
    in_prefix = 1'b0;
    drive(1'b1, 8'h05, 1'b0);
    idle(3);
    chk("tmo_err_sticky", {31'h0, prefix_err}, 32'd1);
    chk("tmo_instr_count", instr_count, 32'(exp_instr));
    chk("tmo_ext_count", {16'h0, ext_count}, 32'(exp_ext));

    pulse_reset("clr");

    // Byte arriving exactly on the timeout cycle completes normally
    drive(1'b1, 8'hff, 1'b0);
    idle(14);
    drive(1'b1, 8'h3c, 1'b0);
    idle(3);
    chk("edge_prefix_err", {31'h0, prefix_err}, 32'd0);
    chk("edge_ext_count", {16'h0, ext_count}, 32'd1);

    // Hold blocks acceptance; one instruction follows release
    for (int unsigned i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'h20;
      hold       = 1'b1;
      #1;
      chk("hold_byte_ready", {31'h0, byte_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    #1;
    chk("hold_release_byte_ready", {31'h0, (hold == 1'b0) ? 1'b0 : byte_ready}, 32'd0);
    drive(1'b1, 8'h20, 1'b0);
    idle(3);
    chk("hold_instr_count", instr_count, 32'd2);

    // Reset while a prefix is pending discards it
    drive(1'b1, 8'hff, 1'b0);
    pulse_reset("prefix_rst");
    drive(1'b1, 8'h2a, 1'b0);
    idle(3);
    chk("post_rst_instr_count", instr_count, 32'd1);
    chk("post_rst_ext_count", {16'h0, ext_count}, 32'd0);
    chk("post_rst_prefix_err", {31'h0, prefix_err}, 32'd0);

    idle(2);
    chk("pending_strobes", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
